// File: rtl/response_sm.sv
// Response packet serialiser: RSN, RC, RDC, then RDC data words onto a stream.
// A stall watchdog pads missing data so every frame still ends with tlast.
module response_sm #(
  parameter int          CNT_W       = 16,
  parameter int          STALL_LIMIT = 1024,
  parameter logic [31:0] PAD_WORD    = 32'hDEAD_BEEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             send_rsp,
  input  logic [31:0]      rsp_ser_num,
  input  logic [31:0]      rsp_code,
  input  logic [CNT_W-1:0] rsp_data_count,
  input  logic [31:0]      rd_data,
  input  logic             rd_valid,
  output logic             rd_ack,
  output logic [31:0]      tx_tdata,
  output logic             tx_tvalid,
  output logic [0:3]       tx_tkeep,
  output logic             tx_tlast,
  input  logic             tx_tready,
  output logic             rsp_busy,
  output logic             rsp_done,
  output logic             rsp_timeout
);

  localparam int SW = $clog2(STALL_LIMIT + 1);

  localparam int B_IDLE = 0;
  localparam int B_RSN  = 1;
  localparam int B_RC   = 2;
  localparam int B_RDC  = 3;
  localparam int B_DATA = 4;
  localparam int B_DONE = 5;

  typedef enum logic [5:0] {
    IDLE      = 6'b000001,
    SEND_RSN  = 6'b000010,
    SEND_RC   = 6'b000100,
    SEND_RDC  = 6'b001000,
    SEND_DATA = 6'b010000,
    DONE      = 6'b100000
  } state_t;

  state_t           state, state_nx;
  logic [31:0]      rsn_q, rc_q;
  logic [CNT_W-1:0] rdc_q;
  logic [CNT_W-1:0] rem_q, rem_nx;
  logic [SW-1:0]    stall_q, stall_nx;
  logic             pad_q, pad_nx;
  logic             tmo_q, tmo_nx;
  logic             ld;
  logic             last_word;

  assign last_word = (rem_q == CNT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rsn_q   <= '0;
      rc_q    <= '0;
      rdc_q   <= '0;
      rem_q   <= '0;
      stall_q <= '0;
      pad_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      rem_q   <= rem_nx;
      stall_q <= stall_nx;
      pad_q   <= pad_nx;
      tmo_q   <= tmo_nx;
      if (ld) begin
        rsn_q <= rsp_ser_num;
        rc_q  <= rsp_code;
        rdc_q <= rsp_data_count;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    rem_nx    = rem_q;
    stall_nx  = stall_q;
    pad_nx    = pad_q;
    tmo_nx    = tmo_q;
    ld        = 1'b0;
    tx_tvalid = 1'b0;
    tx_tdata  = '0;
    tx_tlast  = 1'b0;
    rd_ack    = 1'b0;
    unique case (1'b1)
      state[B_IDLE]: begin
        if (send_rsp) begin
          ld       = 1'b1;
          tmo_nx   = 1'b0;
          state_nx = SEND_RSN;
        end
      end
      state[B_RSN]: begin
        tx_tvalid = 1'b1;
        tx_tdata  = rsn_q;
        if (tx_tready) state_nx = SEND_RC;
      end
      state[B_RC]: begin
        tx_tvalid = 1'b1;
        tx_tdata  = rc_q;
        if (tx_tready) state_nx = SEND_RDC;
      end
      state[B_RDC]: begin
        tx_tvalid = 1'b1;
        tx_tdata  = 32'(rdc_q);
        tx_tlast  = (rdc_q == '0);
        if (tx_tready) begin
          if (rdc_q == '0) begin
            state_nx = DONE;
          end else begin
            rem_nx   = rdc_q;
            stall_nx = '0;
            pad_nx   = 1'b0;
            state_nx = SEND_DATA;
          end
        end
      end
      state[B_DATA]: begin
        tx_tlast = last_word;
        if (pad_q) begin
          tx_tvalid = 1'b1;
          tx_tdata  = PAD_WORD;
          if (tx_tready) begin
            rem_nx = rem_q - CNT_W'(1);
            if (last_word) state_nx = DONE;
          end
        end else begin
          tx_tvalid = rd_valid;
          tx_tdata  = rd_data;
          if (rd_valid) begin
            stall_nx = '0;
            if (tx_tready) begin
              rd_ack = 1'b1;
              rem_nx = rem_q - CNT_W'(1);
              if (last_word) state_nx = DONE;
            end
          end else if (stall_q == SW'(STALL_LIMIT - 1)) begin
            // Source gave up: pad out the rest so the frame still closes
            stall_nx = '0;
            pad_nx   = 1'b1;
            tmo_nx   = 1'b1;
          end else begin
            stall_nx = stall_q + SW'(1);
          end
        end
      end
      state[B_DONE]: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign tx_tkeep    = tx_tvalid ? 4'b1111 : 4'b0000;
  assign rsp_busy    = !state[B_IDLE];
  assign rsp_done    = state[B_DONE];
  assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_response_sm.sv
// Scoreboard bench for response_sm: expected beats queued by stimulus,
// popped and compared by a negedge monitor on every accepted beat.
module tb_response_sm;

  localparam logic [31:0] PAD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        send_rsp;
  logic [31:0] rsp_ser_num;
  logic [31:0] rsp_code;
  logic [15:0] rsp_data_count;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ack;
  logic [31:0] tx_tdata;
  logic        tx_tvalid;
  logic [0:3]  tx_tkeep;
  logic        tx_tlast;
  logic        tx_tready;
  logic        rsp_busy;
  logic        rsp_done;
  logic        rsp_timeout;

  response_sm #(
    .CNT_W(16),
    .STALL_LIMIT(8),
    .PAD_WORD(PAD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .send_rsp(send_rsp),
    .rsp_ser_num(rsp_ser_num),
    .rsp_code(rsp_code),
    .rsp_data_count(rsp_data_count),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .rd_ack(rd_ack),
    .tx_tdata(tx_tdata),
    .tx_tvalid(tx_tvalid),
    .tx_tkeep(tx_tkeep),
    .tx_tlast(tx_tlast),
    .tx_tready(tx_tready),
    .rsp_busy(rsp_busy),
    .rsp_done(rsp_done),
    .rsp_timeout(rsp_timeout)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t       sb_q[$];
  logic [31:0] src_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  int          done_cnt = 0;
  int          ack_cnt = 0;
  logic        tog = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] hold_d;
  logic        hold_l;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Source and sink drivers, updated just after each rising edge
  always @(posedge clk) begin
    #1;
    tx_tready = tog ? !tx_tready : 1'b1;
    rd_valid  = (src_q.size() != 0);
    rd_data   = (src_q.size() != 0) ? src_q[0] : 32'h0;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      check("tkeep", 32'(tx_tkeep), tx_tvalid ? 32'hF : 32'h0);
      if (prev_hold) begin
        check("hold_valid", 32'(tx_tvalid), 32'h1);
        check("hold_data", tx_tdata, hold_d);
        check("hold_last", 32'(tx_tlast), 32'(hold_l));
      end
      prev_hold = tx_tvalid && !tx_tready;
      hold_d    = tx_tdata;
      hold_l    = tx_tlast;
      if (rd_ack) begin
        check("ack_on_accept", 32'(tx_tvalid && tx_tready), 32'h1);
        ack_cnt++;
        if (src_q.size() != 0) void'(src_q.pop_front());
      end
      if (tx_tvalid && tx_tready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h with nothing expected",
                   tx_tdata);
        end else begin
          beat_t e;
          e = sb_q.pop_front();
          check("beat_data", tx_tdata, e.d);
          check("beat_last", 32'(tx_tlast), 32'(e.l));
        end
        if (tx_tlast) last_cyc = cyc;
      end
      if (rsp_done) begin
        done_cnt++;
        check("done_latency", 32'(cyc - last_cyc), 32'h1);
      end
    end
  end

  task automatic push(logic [31:0] d, logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    sb_q.push_back(b);
  endtask

  task automatic start(logic [31:0] rsn, logic [31:0] rc, logic [15:0] rdc);
    @(posedge clk);
    #2;
    send_rsp       = 1'b1;
    rsp_ser_num    = rsn;
    rsp_code       = rc;
    rsp_data_count = rdc;
    @(posedge clk);
    #2;
    send_rsp       = 1'b0;
    rsp_ser_num    = 32'hFFFF_0000;
    rsp_code       = 32'h0000_FFFF;
    rsp_data_count = 16'h7777;
    check("start_valid", 32'(tx_tvalid), 32'h1);
    check("start_rsn", tx_tdata, rsn);
    check("start_busy", 32'(rsp_busy), 32'h1);
    check("start_tmo_clr", 32'(rsp_timeout), 32'h0);
  endtask

  task automatic finish_pkt(string nm, int base_d, int base_a, int acks);
    int i;
    i = 0;
    while (done_cnt == base_d && i < 200) begin
      @(posedge clk);
      i++;
    end
    check({nm, "_done"}, 32'(done_cnt - base_d), 32'h1);
    check({nm, "_acks"}, 32'(ack_cnt - base_a), 32'(acks));
    check({nm, "_sb_empty"}, 32'(sb_q.size()), 32'h0);
  endtask

  initial begin
    int bd;
    int ba;
    int i;
    reset_n        = 1'b0;
    send_rsp       = 1'b0;
    rsp_ser_num    = '0;
    rsp_code       = '0;
    rsp_data_count = '0;
    rd_data        = '0;
    rd_valid       = 1'b0;
    tx_tready      = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", 32'(tx_tvalid), 32'h0);
    check("rst_last", 32'(tx_tlast), 32'h0);
    check("rst_data", tx_tdata, 32'h0);
    check("rst_keep", 32'(tx_tkeep), 32'h0);
    check("rst_ack", 32'(rd_ack), 32'h0);
    check("rst_busy", 32'(rsp_busy), 32'h0);
    check("rst_done", 32'(rsp_done), 32'h0);
    check("rst_tmo", 32'(rsp_timeout), 32'h0);
    reset_n = 1'b1;

    // RDC=0; a queued source word must be left alone
    src_q.push_back(32'hD0);
    bd = done_cnt; ba = ack_cnt;
    push(32'h11, 1'b0);
    push(32'h22, 1'b0);
    push(32'h0, 1'b1);
    start(32'h11, 32'h22, 16'd0);
    finish_pkt("rdc0", bd, ba, 0);
    check("rdc0_src_kept", 32'(src_q.size()), 32'h1);
    src_q.delete();

    // RDC=3, full throughput
    for (int k = 0; k < 3; k++) src_q.push_back(32'hA0 + 32'(k));
    bd = done_cnt; ba = ack_cnt;
    push(32'h1, 1'b0);
    push(32'h2, 1'b0);
    push(32'h3, 1'b0);
    push(32'hA0, 1'b0);
    push(32'hA1, 1'b0);
    push(32'hA2, 1'b1);
    start(32'h1, 32'h2, 16'd3);
    finish_pkt("rdc3", bd, ba, 3);

    // Same packet with tready toggling
    tog = 1'b1;
    for (int k = 0; k < 3; k++) src_q.push_back(32'hA0 + 32'(k));
    bd = done_cnt; ba = ack_cnt;
    push(32'h1, 1'b0);
    push(32'h2, 1'b0);
    push(32'h3, 1'b0);
    push(32'hA0, 1'b0);
    push(32'hA1, 1'b0);
    push(32'hA2, 1'b1);
    start(32'h1, 32'h2, 16'd3);
    finish_pkt("toggle", bd, ba, 3);
    tog = 1'b0;

    // Stall timeout: one real word then three pads
    src_q.push_back(32'hE0);
    bd = done_cnt; ba = ack_cnt;
    push(32'h33, 1'b0);
    push(32'h44, 1'b0);
    push(32'h4, 1'b0);
    push(32'hE0, 1'b0);
    push(PAD, 1'b0);
    push(PAD, 1'b0);
    push(PAD, 1'b1);
    start(32'h33, 32'h44, 16'd4);
    finish_pkt("stall", bd, ba, 1);
    check("stall_tmo", 32'(rsp_timeout), 32'h1);

    // Second start during SEND_RC is ignored
    src_q.push_back(32'hF0);
    bd = done_cnt; ba = ack_cnt;
    push(32'h5A, 1'b0);
    push(32'h5B, 1'b0);
    push(32'h1, 1'b0);
    push(32'hF0, 1'b1);
    start(32'h5A, 32'h5B, 16'd1);
    @(posedge clk);
    #2;
    send_rsp    = 1'b1;
    rsp_ser_num = 32'hBAD;
    @(posedge clk);
    #2;
    send_rsp = 1'b0;
    finish_pkt("ignore", bd, ba, 1);
    repeat (10) @(posedge clk);
    #2;
    check("ignore_idle", 32'(rsp_busy), 32'h0);
    check("ignore_one_frame", 32'(done_cnt - bd), 32'h1);

    // Reset mid data phase with two words still owed
    src_q.push_back(32'hB0);
    src_q.push_back(32'hB1);
    ba = ack_cnt;
    push(32'h55, 1'b0);
    push(32'h66, 1'b0);
    push(32'h4, 1'b0);
    push(32'hB0, 1'b0);
    push(32'hB1, 1'b0);
    start(32'h55, 32'h66, 16'd4);
    i = 0;
    while (ack_cnt - ba < 2 && i < 50) begin
      @(posedge clk);
      i++;
    end
    check("rst_mid_acks", 32'(ack_cnt - ba), 32'h2);
    check("rst_mid_sb", 32'(sb_q.size()), 32'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(tx_tvalid), 32'h0);
    check("rst_mid_busy", 32'(rsp_busy), 32'h0);
    check("rst_mid_last", 32'(tx_tlast), 32'h0);
    src_q.delete();
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;

    src_q.push_back(32'hC0);
    bd = done_cnt; ba = ack_cnt;
    push(32'h77, 1'b0);
    push(32'h88, 1'b0);
    push(32'h1, 1'b0);
    push(32'hC0, 1'b1);
    start(32'h77, 32'h88, 16'd1);
    finish_pkt("post_rst", bd, ba, 1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
